multicycle_seq: RTL and testbench
=================================

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 The block SHALL have these ports: run, input, 1, leave IDLE and keep starting instructions while high.
REQ-004 The block SHALL have these ports: RegWrite, MemRead, MemWrite, branch, JAL, JALR, inputs, 1 each, decoder outputs for the instruction in IR, stable from DECODE through retire.
REQ-005 The block SHALL have these ports: br_taken, input, 1, branch comparison result, valid in EXEC.
REQ-006 The block SHALL have these ports: illegal, input, 1, decoder found an unsupported opcode or funct, valid in DECODE.
REQ-007 The block SHALL have these ports: imem_req, output, 1, instruction fetch request; imem_ready, input, 1, fetch data valid.
REQ-008 The block SHALL have these ports: dmem_req, output, 1, data access request; dmem_we, output, 1, write strobe; dmem_ready, input, 1, access complete.
REQ-009 The block SHALL have these ports: ir_we, pc_we, reg_we, outputs, 1 each, load IR, load PC, write register file.
REQ-010 The block SHALL have these ports: pc_sel, output, 2, next-PC select: 00 = pc+4, 01 = branch/JAL target, 10 = JALR target.
REQ-011 The block SHALL have these ports: state, output, 3, current state code.
REQ-012 The block SHALL have these ports: trap, output, 1, sequencer halted on error; trap_cause, output, 1, 0 = illegal, 1 = bus timeout.
REQ-013 The block SHALL have these ports: instret, output, 32, retired-instruction counter.

Function
REQ-014 The state codes SHALL be IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6; code 7 SHALL go to IDLE on the next cycle.
REQ-015 All outputs except state and instret SHALL be combinational decodes of the state register and the listed inputs, and SHALL be 0 in IDLE.
REQ-016 IDLE: run = 1 SHALL transition to FETCH; otherwise the block stays in IDLE.
REQ-017 FETCH: the block SHALL assert imem_req; when imem_ready = 1 (including the first cycle of the request) it SHALL pulse ir_we and go to DECODE; otherwise it holds.
REQ-018 DECODE: the state SHALL last exactly 1 cycle; illegal = 1 SHALL go to TRAP with trap_cause = 0; otherwise the block goes to EXEC.
REQ-019 EXEC: the state SHALL last 1 cycle; MemRead|MemWrite SHALL go to MEM; otherwise RegWrite SHALL go to WB; otherwise (taken or untaken branch) the block retires.
REQ-020 MEM: the block SHALL assert dmem_req, with dmem_we = MemWrite; on dmem_ready a load SHALL go to WB and a store SHALL retire; otherwise it holds.
REQ-021 WB: the block SHALL assert reg_we = RegWrite for 1 cycle, then retire.
REQ-022 Retire: pc_we SHALL be high for exactly 1 cycle per instruction, and instret SHALL increment by 1 in the same cycle, wrapping from 0xFFFFFFFF to 0.
REQ-023 After retire, the next state SHALL be FETCH if run = 1, else IDLE; run falling mid-instruction SHALL NOT abort it.
REQ-024 pc_sel SHALL be 10 if JALR, else 01 if JAL or (branch & br_taken), else 00.
REQ-025 pc_sel SHALL be meaningful only while pc_we = 1, and SHALL be 00 otherwise.
REQ-026 Instruction latency with zero-wait memory SHALL be: branch 3 cycles, ALU/JAL/JALR/LUI/AUIPC 4, store 4, load 5, counted from FETCH entry to the retire cycle inclusive.
REQ-027 TRAP SHALL be sticky: trap = 1, all request and write strobes 0, and instret frozen until reset.
REQ-028 The block SHALL ignore imem_ready outside FETCH and dmem_ready outside MEM.

Reset
REQ-029 When rst_n = 0 at a rising edge of clk, the block SHALL set state = IDLE, instret = 0, the timeout counter = 0, and trap_cause = 0.
REQ-030 Reset asserted mid-instruction, including during an outstanding request, SHALL abandon the instruction, with strobes low from the following cycle and no retire.

Configuration
REQ-031 With MC_SEQ_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle the corresponding ready is low.
REQ-032 With MC_SEQ_TIMEOUT_EN defined, a count of 255 with ready still low SHALL go to TRAP with trap_cause = 1.
REQ-033 Without MC_SEQ_TIMEOUT_EN defined, the block SHALL have no counter, SHALL wait indefinitely, and trap_cause SHALL be constant 0.

Verification
REQ-034 ADDI stream, zero-wait, run = 1: the bench SHALL see states 1,2,3,5 repeating, one pc_we per 4 cycles, and instret = 10 after 40 cycles.
REQ-035 Load with dmem_ready delayed 3 cycles: the bench SHALL see MEM held for 4 cycles, dmem_we = 0, then WB with reg_we = 1, pc_sel = 00, and retire.
REQ-036 Taken BEQ, then JALR: the bench SHALL see pc_sel = 01 on the first retire with no reg_we, then pc_sel = 10 with reg_we = 1.
REQ-037 illegal = 1 in DECODE: the bench SHALL see trap = 1 and trap_cause = 0, with no further imem_req, and state = 0, trap = 0 after rst_n is asserted.
REQ-038 With MC_SEQ_TIMEOUT_EN defined and imem_ready held low: the bench SHALL see TRAP after 256 FETCH cycles with trap_cause = 1; without the macro, the bench SHALL see FETCH held indefinitely.
REQ-039 rst_n pulsed low during MEM of a store: the bench SHALL see dmem_req low the next cycle, instret unchanged, and the state at IDLE.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes, retire counter, sticky trap.
// Optional MC_SEQ_TIMEOUT_EN adds an 8-bit bus wait counter that traps after 255 wait cycles.
module multicycle_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        branch,
    input  logic        JAL,
    input  logic        JALR,
    input  logic        br_taken,
    input  logic        illegal,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic        trap,
    output logic        trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t      state_reg, state_next;
    logic        retire;
    logic [31:0] instret_reg;

`ifdef MC_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       cause_reg, cause_next;
    logic       timeout;
`endif

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
`ifdef MC_SEQ_TIMEOUT_EN
        timeout    = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
`ifdef MC_SEQ_TIMEOUT_EN
                else if (wait_cnt_reg == 8'hFF) begin
                    state_next = S_TRAP;
                    timeout    = 1'b1;
                end
`endif
            end
            S_DECODE: begin
                state_next = illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (MemRead | MemWrite) state_next = S_MEM;
                else if (RegWrite)      state_next = S_WB;
                else                    retire     = 1'b1;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
                if (dmem_ready) begin
                    if (MemRead) state_next = S_WB;
                    else         retire     = 1'b1;
                end
`ifdef MC_SEQ_TIMEOUT_EN
                else if (wait_cnt_reg == 8'hFF) begin
                    state_next = S_TRAP;
                    timeout    = 1'b1;
                end
`endif
            end
            S_WB: begin
                reg_we = RegWrite;
                retire = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Retire always finishes the instruction; run only decides what follows it.
        if (retire) state_next = run ? S_FETCH : S_IDLE;
    end

    assign pc_we = retire;

    always_comb begin
        pc_sel = 2'b00;
        if (retire) begin
            if (JALR)                           pc_sel = 2'b10;
            else if (JAL | (branch & br_taken)) pc_sel = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) instret_reg <= instret_reg + 32'd1;
        end
    end

`ifdef MC_SEQ_TIMEOUT_EN
    // Any state change clears the count, so it starts at zero on every FETCH/MEM entry.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = 8'd0;
        else if ((state_reg == S_FETCH && !imem_ready) || (state_reg == S_MEM && !dmem_ready))
            wait_cnt_next = wait_cnt_reg + 8'd1;
    end

    always_comb begin
        cause_next = cause_reg;
        if (state_reg != S_TRAP && state_next == S_TRAP) cause_next = timeout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= 8'd0;
            cause_reg    <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            cause_reg    <= cause_next;
        end
    end

    assign trap_cause = trap & cause_reg;
`else
    assign trap_cause = 1'b0;
`endif

    assign state   = state_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: a responder plays instruction/data memory and decoder, a scoreboard
// of per-instruction expectations is checked at every retire; directed scenarios cover traps and reset.
`timescale 1ns/1ps
module tb_multicycle_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        branch = 1'b0, JAL = 1'b0, JALR = 1'b0, br_taken = 1'b0, illegal = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap, trap_cause;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_seq dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .branch(branch), .JAL(JAL), .JALR(JALR), .br_taken(br_taken), .illegal(illegal),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_sel(pc_sel),
        .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    typedef enum int {K_ALU, K_JAL, K_JALR, K_BRT, K_BRN, K_LOAD, K_STORE, K_ILL} kind_t;
    typedef struct { kind_t kind; int iw; int dw; } plan_t;
    typedef struct { int sel; int rwe; int dwe; int lat; int start; int idx; } exp_t;

    plan_t plan_q[$];
    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    model_count = 0;
    int    n_retired = 0;
    int    cycle = 0;
    bit    rand_en = 1'b0;
    int    st_cnt[8];
    bit    dwe_seen, rwe_seen;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: per-instruction outcome from the instruction class and the memory waits.
    function automatic exp_t expect_for(input plan_t p, input int start);
        exp_t e;
        e.sel = (p.kind == K_JALR) ? 2 : ((p.kind == K_JAL || p.kind == K_BRT) ? 1 : 0);
        e.rwe = (p.kind == K_ALU || p.kind == K_JAL || p.kind == K_JALR || p.kind == K_LOAD) ? 1 : 0;
        e.dwe = (p.kind == K_STORE) ? 1 : 0;
        case (p.kind)
            K_BRT, K_BRN: e.lat = 3;
            K_STORE:      e.lat = 4 + p.dw;
            K_LOAD:       e.lat = 5 + p.dw;
            default:      e.lat = 4;
        endcase
        e.lat   = e.lat + p.iw;
        e.start = start;
        e.idx   = model_count;
        return e;
    endfunction

    task automatic apply_decode(input kind_t k);
        RegWrite = (k == K_ALU || k == K_JAL || k == K_JALR || k == K_LOAD);
        MemRead  = (k == K_LOAD);
        MemWrite = (k == K_STORE);
        branch   = (k == K_BRT || k == K_BRN);
        JAL      = (k == K_JAL);
        JALR     = (k == K_JALR);
        illegal  = (k == K_ILL);
        if (k == K_BRT)      br_taken = 1'b1;
        else if (k == K_BRN) br_taken = 1'b0;
        else                 br_taken = 1'($urandom_range(1, 0));
    endtask

    // Memory/decoder responder; ready lines carry random noise whenever no request is pending.
    initial begin : driver
        int    iw_left;
        int    dw_left;
        bit    in_fetch;
        plan_t p;
        iw_left = 0; dw_left = 0; in_fetch = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) in_fetch = 1'b0;
            if (imem_req) begin
                if (!in_fetch) begin
                    if (plan_q.size() > 0) p = plan_q.pop_front();
                    else if (rand_en) begin
                        p.kind = kind_t'($urandom_range(6, 0));
                        p.iw   = $urandom_range(3, 0);
                        p.dw   = $urandom_range(3, 0);
                    end else begin
                        p.kind = K_ALU; p.iw = 0; p.dw = 0;
                    end
                    apply_decode(p.kind);
                    if (p.kind != K_ILL) begin
                        sb_q.push_back(expect_for(p, cycle));
                        model_count++;
                    end
                    iw_left  = p.iw;
                    dw_left  = p.dw;
                    in_fetch = 1'b1;
                end
                if (iw_left == 0) begin
                    imem_ready = 1'b1;
                    in_fetch   = 1'b0;
                end else begin
                    imem_ready = 1'b0;
                    iw_left--;
                end
            end else imem_ready = 1'($urandom_range(1, 0));
            if (dmem_req) begin
                if (dw_left == 0) dmem_ready = 1'b1;
                else begin
                    dmem_ready = 1'b0;
                    dw_left--;
                end
            end else dmem_ready = 1'($urandom_range(1, 0));
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pc_we) begin
                    if (sb_q.size() == 0) chk("retire_unexpected", 32'(pc_we), 32'd0);
                    else begin
                        e = sb_q.pop_front();
                        n_retired++;
                        chk("pc_sel", 32'(pc_sel), e.sel);
                        chk("reg_we_at_retire", 32'(reg_we), e.rwe);
                        chk("dmem_we_at_retire", 32'(dmem_we), e.dwe);
                        chk("instret_at_retire", instret, e.idx);
                        chk("latency", cycle - e.start + 1, e.lat);
                    end
                end else chk("pc_sel_no_retire", 32'(pc_sel), 32'd0);
                if (state == 3'd0)
                    chk("idle_outputs", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap, trap_cause}), 32'd0);
                if (state == 3'd6)
                    chk("trap_strobes", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we}), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        plan_q.delete();
        model_count = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_for_state(input int s, input int limit, input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (state != 3'(s) && g < limit) begin
            @(negedge clk);
            g++;
        end
        chk(name, 32'(state), s);
    endtask

    // Issues one instruction, drops run after FETCH entry and profiles the states it visits.
    task automatic run_one(input kind_t k, input int iw, input int dw);
        plan_t p;
        int    g;
        p.kind = k; p.iw = iw; p.dw = dw;
        plan_q.push_back(p);
        foreach (st_cnt[i]) st_cnt[i] = 0;
        dwe_seen = 1'b0;
        rwe_seen = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        wait_for_state(1, 20, "run_one_fetch");
        run = 1'b0;
        g = 0;
        while (state != 3'd0 && state != 3'd6 && g < 300) begin
            st_cnt[state]++;
            if (state == 3'd4 && dmem_we) dwe_seen = 1'b1;
            if (state == 3'd5 && reg_we)  rwe_seen = 1'b1;
            @(negedge clk);
            g++;
        end
        chk("run_one_bound", 32'(g < 300), 32'd1);
    endtask

    function automatic int total_cycles();
        int s;
        s = 0;
        foreach (st_cnt[i]) s += st_cnt[i];
        return s;
    endfunction

    initial begin : main
        int pat[4];
        int pcw;
        int g;
        int fc;
        bit imem_seen;
        plan_t p;
        pat = '{1, 2, 3, 5};

        do_reset();
        @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_trap", 32'({trap, trap_cause}), 32'd0);

        // Zero-wait ALU stream.
        @(posedge clk); #1;
        run = 1'b1;
        wait_for_state(1, 20, "addi_start");
        pcw = 0;
        for (int i = 0; i < 40; i++) begin
            chk("addi_state", 32'(state), pat[i % 4]);
            pcw += int'(pc_we);
            @(negedge clk);
        end
        chk("addi_instret", instret, 32'd10);
        chk("addi_pc_we_count", pcw, 32'd10);
        run = 1'b0;
        wait_for_state(0, 20, "addi_idle");

        // Load with three data wait cycles.
        run_one(K_LOAD, 0, 3);
        chk("load_mem_cycles", st_cnt[4], 32'd4);
        chk("load_dmem_we", 32'(dwe_seen), 32'd0);
        chk("load_wb_cycles", st_cnt[5], 32'd1);
        chk("load_reg_we", 32'(rwe_seen), 32'd1);
        chk("load_latency", total_cycles(), 32'd8);

        // Taken branch then JALR.
        run_one(K_BRT, 0, 0);
        chk("beq_latency", total_cycles(), 32'd3);
        chk("beq_no_wb", st_cnt[5], 32'd0);
        run_one(K_JALR, 0, 0);
        chk("jalr_reg_we", 32'(rwe_seen), 32'd1);
        chk("jalr_latency", total_cycles(), 32'd4);

        // Randomized mix with random waits and run toggling.
        do_reset();
        n_retired = 0;
        rand_en = 1'b1;
        g = 0;
        while (n_retired < 150 && g < 8000) begin
            @(posedge clk); #1;
            run = ($urandom_range(3, 0) != 0);
            g++;
        end
        rand_en = 1'b0;
        run = 1'b0;
        wait_for_state(0, 50, "rand_idle");
        chk("rand_retired", 32'(n_retired >= 150), 32'd1);
        chk("rand_sb_empty", sb_q.size(), 32'd0);
        chk("rand_instret", instret, model_count);

        // Reset during MEM of a store.
        do_reset();
        p.kind = K_STORE; p.iw = 0; p.dw = 20;
        plan_q.push_back(p);
        @(posedge clk); #1;
        run = 1'b1;
        wait_for_state(4, 30, "store_mem");
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mem_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_mem_state", 32'(state), 32'd0);
        chk("rst_mem_instret", instret, 32'd0);
        sb_q.delete();
        model_count = 0;
        rst_n = 1'b1;

        // Illegal instruction traps and stays trapped.
        do_reset();
        run_one(K_ILL, 0, 0);
        chk("ill_state", 32'(state), 32'd6);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd0);
        run = 1'b1;
        imem_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req) imem_seen = 1'b1;
        end
        chk("ill_no_fetch", 32'(imem_seen), 32'd0);
        chk("ill_held", 32'(state), 32'd6);
        chk("ill_instret", instret, model_count);
        do_reset();
        @(negedge clk);
        chk("ill_reset_state", 32'(state), 32'd0);
        chk("ill_reset_trap", 32'(trap), 32'd0);

        // Instruction fetch that never completes.
        p.kind = K_ALU; p.iw = 100000; p.dw = 0;
        plan_q.push_back(p);
        @(posedge clk); #1;
        run = 1'b1;
        wait_for_state(1, 20, "to_fetch");
        run = 1'b0;
        fc = 0;
`ifdef MC_SEQ_TIMEOUT_EN
        while (state == 3'd1 && fc < 400) begin
            fc++;
            @(negedge clk);
        end
        chk("to_fetch_cycles", fc, 32'd256);
        chk("to_state", 32'(state), 32'd6);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd1);
`else
        for (int i = 0; i < 600; i++) begin
            if (state == 3'd1) fc++;
            @(negedge clk);
        end
        chk("hold_fetch_cycles", fc, 32'd600);
        chk("hold_imem_req", 32'(imem_req), 32'd1);
        chk("hold_no_trap", 32'(trap), 32'd0);
`endif
        do_reset();
        @(negedge clk);
        chk("final_state", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
